// File: rtl/regfile_32x64.sv
// regfile_32x64 -- 32 x WIDTH general-purpose register file.
//
// One synchronous write port and two combinational read ports. X31 has no
// storage and always reads as zero. Per-register write strobes come from
// decoder5_32, which is driven by the write address and the raw write enable.
//
// Ports:
//   clk             system clock; state updates on the rising edge
//   reset_n         asynchronous active-low reset; clears X0..X30
//   reg_write       write enable for the current cycle
//   write_register  write address (5 bits)
//   write_data      data to write (WIDTH bits)
//   read_register1  read port 1 address
//   read_register2  read port 2 address
//   read_data1      read port 1 data (combinational)
//   read_data2      read port 2 data (combinational)
//
// Parameter BYPASS=1 forwards a same-cycle write to any read port whose
// address matches (never for X31, never during reset).

// decoder5_32 -- enable-gated 5-to-32 one-hot decoder.
//   in        address to decode
//   regWrite  enable; all outputs are 0 when low
//   out       one-hot strobe vector
module decoder5_32 (
    input  logic [4:0]  in,
    input  logic        regWrite,
    output logic [31:0] out
);
    always_comb begin
        out = '0;
        if (regWrite) begin
            out[in] = 1'b1;
        end
    end
endmodule

module regfile_32x64 #(
    parameter int WIDTH  = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reg_write,
    input  logic [4:0]       write_register,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       read_register1,
    input  logic [4:0]       read_register2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);
    localparam logic [4:0] XZR = 5'd31;

    logic [WIDTH-1:0] regs [0:30];
    logic [30:0]      wr_en;
    logic             unused_x31_strobe;   // X31 has no storage; strobe dropped

    decoder5_32 u_dec (
        .in       (write_register),
        .regWrite (reg_write),
        .out      ({unused_x31_strobe, wr_en})
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 31; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 31; i++) begin
                if (wr_en[i[4:0]]) begin
                    regs[i[4:0]] <= write_data;
                end
            end
        end
    end

    // Forwarding condition per port; reset_n gates it so reads are 0 in reset.
    logic byp1, byp2;
    assign byp1 = BYPASS && reset_n && reg_write &&
                  (write_register == read_register1) && (write_register != XZR);
    assign byp2 = BYPASS && reset_n && reg_write &&
                  (write_register == read_register2) && (write_register != XZR);

    always_comb begin
        read_data1 = '0;
        if (!reset_n) begin
            read_data1 = '0;
        end else if (byp1) begin
            read_data1 = write_data;
        end else if (read_register1 != XZR) begin
            read_data1 = regs[read_register1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (!reset_n) begin
            read_data2 = '0;
        end else if (byp2) begin
            read_data2 = write_data;
        end else if (read_register2 != XZR) begin
            read_data2 = regs[read_register2];
        end
    end
endmodule

// File: tb/tb_regfile_32x64.sv
// Testbench for regfile_32x64: two instances (BYPASS=1 and BYPASS=0) share
// the same stimulus. A reference array tracks register contents; a compare
// process checks all four read ports against it every cycle, and directed
// literal expectations pin specific scenarios.
module tb_regfile_32x64;
    logic        clk;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [63:0] write_data;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int errors = 0;
    int checks = 0;

    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
        .write_register(write_register), .write_data(write_data),
        .read_register1(read_register1), .read_register2(read_register2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
        .write_register(write_register), .write_data(write_data),
        .read_register1(read_register1), .read_register2(read_register2),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference contents of X0..X30.
    logic [63:0] mdl [0:30];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            foreach (mdl[k]) mdl[k] <= 64'd0;
        end else if (reg_write && write_register != 5'd31) begin
            mdl[write_register] <= write_data;
        end
    end

    function automatic logic [63:0] expect_read(input logic [4:0] ra, input bit byp);
        if (!reset_n) return 64'd0;
        if (byp && reg_write && write_register == ra && write_register != 5'd31)
            return write_data;
        if (ra == 5'd31) return 64'd0;
        return mdl[ra];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison, sampled mid low-phase after inputs settle.
    always @(negedge clk) begin
        #3;
        check("cmp_byp_rd1", rd1_b, expect_read(read_register1, 1'b1));
        check("cmp_byp_rd2", rd2_b, expect_read(read_register2, 1'b1));
        check("cmp_nob_rd1", rd1_n, expect_read(read_register1, 1'b0));
        check("cmp_nob_rd2", rd2_n, expect_read(read_register2, 1'b0));
    end

    // Drive one cycle's inputs shortly after the falling edge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        #1;
        reg_write      = we;
        write_register = wa;
        write_data     = wd;
        read_register1 = r1;
        read_register2 = r2;
    endtask

    initial begin
        reset_n        = 1'b0;
        reg_write      = 1'b1;
        write_register = 5'd5;
        write_data     = 64'hDEAD_BEEF;
        read_register1 = 5'd5;
        read_register2 = 5'd5;

        // Writes are ignored while in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_byp_rd1", rd1_b, 64'd0);
        check("rst_byp_rd2", rd2_b, 64'd0);
        check("rst_nob_rd1", rd1_n, 64'd0);
        check("rst_nob_rd2", rd2_n, 64'd0);

        @(negedge clk);
        #1;
        reset_n   = 1'b1;
        reg_write = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_x5", rd1_b, 64'd0);
        check("post_rst_x5_nob", rd2_n, 64'd0);

        // Fill every register, then sweep both ports.
        for (int i = 0; i < 31; i++) begin
            cycle(1'b1, 5'(i), 64'h1000 + 64'(i), 5'(i), 5'd31);
        end
        for (int i = 0; i < 31; i++) begin
            cycle(1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i));
            #1;
            check("sweep_rd1", rd1_b, 64'h1000 + 64'(i));
            check("sweep_rd2", rd2_n, 64'h1000 + 64'(30 - i));
        end
        cycle(1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
        #1;
        check("x31_rd1", rd1_b, 64'd0);
        check("x31_rd2", rd2_n, 64'd0);

        // Writing X31 has no effect and never forwards.
        cycle(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30);
        #1;
        check("x31w_pre_rd1", rd1_b, 64'd0);
        check("x31w_pre_rd2", rd2_b, 64'h101E);
        @(posedge clk);
        #1;
        check("x31w_post_rd1", rd1_b, 64'd0);
        check("x31w_post_rd2", rd2_n, 64'h101E);

        // Disabled write leaves X7 alone.
        cycle(1'b1, 5'd7, 64'h55, 5'd7, 5'd7);
        cycle(1'b0, 5'd7, 64'hAA, 5'd7, 5'd7);
        #1;
        check("wdis_pre", rd1_b, 64'h55);
        @(posedge clk);
        #1;
        check("wdis_post_byp", rd2_b, 64'h55);
        check("wdis_post_nob", rd1_n, 64'h55);

        // Same-cycle forwarding versus no forwarding.
        cycle(1'b1, 5'd3, 64'h11, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 64'h22, 5'd3, 5'd3);
        #1;
        check("byp_pre_rd1", rd1_b, 64'h22);
        check("byp_pre_rd2", rd2_b, 64'h22);
        check("nob_pre_rd1", rd1_n, 64'h11);
        check("nob_pre_rd2", rd2_n, 64'h11);
        @(posedge clk);
        #1;
        check("nob_post_rd1", rd1_n, 64'h22);
        check("nob_post_rd2", rd2_n, 64'h22);

        // Asynchronous reset pulse between clock edges.
        cycle(1'b1, 5'd9, 64'h1234, 5'd9, 5'd9);
        cycle(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
        #1;
        check("x9_before", rd1_b, 64'h1234);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_byp", rd1_b, 64'd0);
        check("arst_nob", rd1_n, 64'd0);
        #2;
        reset_n = 1'b1;
        repeat (2) cycle(1'b0, 5'd9, 64'h99, 5'd9, 5'd3);
        #1;
        check("arst_after_x9", rd1_b, 64'd0);
        check("arst_after_x3", rd2_n, 64'd0);

        // First write after reset is accepted.
        cycle(1'b1, 5'd9, 64'h77, 5'd1, 5'd1);
        cycle(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
        #1;
        check("rewrite_x9", rd1_n, 64'h77);

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
